// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch compare/target and destination select,
// registered into the EX/MEM pipeline register. branchDet flushes the upstream registers.
module ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pcvalue,
    input  logic [DW-1:0] rsDt,
    input  logic [DW-1:0] rtDt,
    input  logic [DW-1:0] signEx,
    input  logic [AW-1:0] rsval,
    input  logic [AW-1:0] rtval,
    input  logic [AW-1:0] rdval,
    input  logic          memtoreg,
    input  logic          memwrite,
    input  logic          memRead,
    input  logic          branch,
    input  logic          aluSrc,
    input  logic          regdst,
    input  logic          regwrite,
    input  logic [2:0]    aluControl,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_writereg,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] aluOutStored,
    output logic [DW-1:0] writeDataStored,
    output logic [AW-1:0] writeRegStored,
    output logic [DW-1:0] branchTarget,
    output logic          memtoregStored,
    output logic          memwriteStored,
    output logic          memReadStored,
    output logic          regwriteStored,
    output logic          branchDet
);

    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] btgt_q, btgt_d;
    logic          mtr_q, mtr_d;
    logic          mw_q, mw_d;
    logic          mr_q, mr_d;
    logic          rw_q, rw_d;
    logic          bdet_q, bdet_d;

    logic [DW-1:0] fwd_a, fwd_b, src_b;
    logic          mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic          squash;

    // MEM-stage result beats WB; register 0 is hardwired and never forwarded.
    always_comb begin
        mem_hit_a = rw_q && (wreg_q != '0) && (wreg_q == rsval);
        mem_hit_b = rw_q && (wreg_q != '0) && (wreg_q == rtval);
        wb_hit_a  = wb_regwrite && (wb_writereg != '0) && (wb_writereg == rsval);
        wb_hit_b  = wb_regwrite && (wb_writereg != '0) && (wb_writereg == rtval);

        fwd_a = rsDt;
        if (mem_hit_a)     fwd_a = alu_q;
        else if (wb_hit_a) fwd_a = wb_result;

        fwd_b = rtDt;
        if (mem_hit_b)     fwd_b = alu_q;
        else if (wb_hit_b) fwd_b = wb_result;

        src_b = aluSrc ? signEx : fwd_b;
    end

    always_comb begin
        alu_d = '0;
        case (aluControl)
            3'b010:  alu_d = fwd_a + src_b;
            3'b110:  alu_d = fwd_a - src_b;
            3'b000:  alu_d = fwd_a & src_b;
            3'b001:  alu_d = fwd_a | src_b;
            3'b111:  alu_d = {{(DW-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
            default: alu_d = '0;
        endcase
    end

    // A taken branch registered last cycle means the instruction now in EX is wrong-path.
    always_comb begin
        squash  = bdet_q;
        wdata_d = fwd_b;
        wreg_d  = regdst ? rdval : rtval;
        btgt_d  = pcvalue + (signEx << 2);
        mtr_d   = memtoreg;
        mw_d    = memwrite & ~squash;
        mr_d    = memRead & ~squash;
        rw_d    = regwrite & ~squash;
        bdet_d  = branch & (alu_d == '0) & ~squash;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q   <= '0;
            wdata_q <= '0;
            wreg_q  <= '0;
            btgt_q  <= '0;
            mtr_q   <= 1'b0;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            rw_q    <= 1'b0;
            bdet_q  <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
            btgt_q  <= btgt_d;
            mtr_q   <= mtr_d;
            mw_q    <= mw_d;
            mr_q    <= mr_d;
            rw_q    <= rw_d;
            bdet_q  <= bdet_d;
        end
    end

    assign aluOutStored    = alu_q;
    assign writeDataStored = wdata_q;
    assign writeRegStored  = wreg_q;
    assign branchTarget    = btgt_q;
    assign memtoregStored  = mtr_q;
    assign memwriteStored  = mw_q;
    assign memReadStored   = mr_q;
    assign regwriteStored  = rw_q;
    assign branchDet       = bdet_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic against an
// instruction-level model of the EX/MEM register contents.
module tb_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pcvalue, rsDt, rtDt, signEx, wb_result;
    logic [AW-1:0] rsval, rtval, rdval, wb_writereg;
    logic          memtoreg, memwrite, memRead, branch, aluSrc, regdst, regwrite, wb_regwrite;
    logic [2:0]    aluControl;
    logic [DW-1:0] aluOutStored, writeDataStored, branchTarget;
    logic [AW-1:0] writeRegStored;
    logic          memtoregStored, memwriteStored, memReadStored, regwriteStored, branchDet;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected EX/MEM contents
    logic [DW-1:0] e_alu, e_wd, e_bt;
    logic [AW-1:0] e_wr;
    logic          e_mtr, e_mw, e_mr, e_rw, e_bd;

    ex_stage #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pcvalue(pcvalue), .rsDt(rsDt), .rtDt(rtDt),
        .signEx(signEx), .rsval(rsval), .rtval(rtval), .rdval(rdval),
        .memtoreg(memtoreg), .memwrite(memwrite), .memRead(memRead), .branch(branch),
        .aluSrc(aluSrc), .regdst(regdst), .regwrite(regwrite), .aluControl(aluControl),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
        .aluOutStored(aluOutStored), .writeDataStored(writeDataStored),
        .writeRegStored(writeRegStored), .branchTarget(branchTarget),
        .memtoregStored(memtoregStored), .memwriteStored(memwriteStored),
        .memReadStored(memReadStored), .regwriteStored(regwriteStored), .branchDet(branchDet)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu"},  aluOutStored, e_alu);
        chk({tag, ".wd"},   writeDataStored, e_wd);
        chk({tag, ".wr"},   DW'(writeRegStored), DW'(e_wr));
        chk({tag, ".bt"},   branchTarget, e_bt);
        chk({tag, ".mtr"},  DW'(memtoregStored), DW'(e_mtr));
        chk({tag, ".mw"},   DW'(memwriteStored), DW'(e_mw));
        chk({tag, ".mr"},   DW'(memReadStored), DW'(e_mr));
        chk({tag, ".rw"},   DW'(regwriteStored), DW'(e_rw));
        chk({tag, ".bd"},   DW'(branchDet), DW'(e_bd));
    endtask

    task automatic model_reset();
        e_alu = '0; e_wd = '0; e_bt = '0; e_wr = '0;
        e_mtr = 0; e_mw = 0; e_mr = 0; e_rw = 0; e_bd = 0;
    endtask

    function automatic logic [DW-1:0] operand(input logic [AW-1:0] r, input logic [DW-1:0] rf);
        if (e_rw && e_wr != 0 && e_wr == r)                 return e_alu;
        if (wb_regwrite && wb_writereg != 0 && wb_writereg == r) return wb_result;
        return rf;
    endfunction

    // One instruction through EX: predict, clock, compare.
    task automatic step(input string tag);
        logic [DW-1:0] a, fb, b, r;
        logic          wrong_path;
        longint        sa, sb;
        a  = operand(rsval, rsDt);
        fb = operand(rtval, rtDt);
        b  = aluSrc ? signEx : fb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (int'(aluControl))
            2:       r = DW'(longint'(a) + longint'(b));
            6:       r = DW'(longint'(a) - longint'(b));
            0:       r = a & b;
            1:       r = a | b;
            7:       r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        wrong_path = e_bd;
        @(posedge clk);
        #1;
        e_alu = r;
        e_wd  = fb;
        e_wr  = regdst ? rdval : rtval;
        e_bt  = DW'(longint'(pcvalue) + longint'(signEx) * 4);
        e_mtr = memtoreg;
        e_mw  = memwrite && !wrong_path;
        e_mr  = memRead && !wrong_path;
        e_rw  = regwrite && !wrong_path;
        e_bd  = branch && (r == 0) && !wrong_path;
        check_all(tag);
    endtask

    task automatic clear_in();
        pcvalue = 0; rsDt = 0; rtDt = 0; signEx = 0; wb_result = 0;
        rsval = 1; rtval = 2; rdval = 0; wb_writereg = 0;
        memtoreg = 0; memwrite = 0; memRead = 0; branch = 0; aluSrc = 0;
        regdst = 0; regwrite = 0; wb_regwrite = 0; aluControl = 3'b010;
    endtask

    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [2:0]    ops  [6] = '{3'b010, 3'b110, 3'b111, 3'b000, 3'b001, 3'b100};
    logic [DW-1:0] opsx [6] = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0};

    initial begin
        clear_in();
        model_reset();
        #1;
        check_all("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mid-cycle reset with regwriteStored set
        regwrite = 1; regdst = 1; rdval = 4; rsDt = 3;
        step("pre_rst");
        mid_reset("rst_mid");
        clear_in();
        rsDt = 5; rtDt = 7;
        step("add57");
        chk("add57_val", aluOutStored, 32'd12);

        // Forward priority: MEM over WB
        clear_in();
        rsDt = 32'h10; regwrite = 1; regdst = 1; rdval = 3;
        step("fw_prod");
        clear_in();
        rsval = 3; rtval = 3; rsDt = 32'hDEAD; rtDt = 32'hBEEF;
        wb_regwrite = 1; wb_writereg = 3; wb_result = 32'h99;
        step("fw_mem");
        chk("fw_mem_val", aluOutStored, 32'h20);

        // Writes to r0 are never forwarded
        clear_in();
        rsDt = 32'h77; regwrite = 1; regdst = 1; rdval = 0;
        step("r0_prod");
        clear_in();
        rsval = 0; rtval = 0; rsDt = 1; rtDt = 1;
        wb_regwrite = 1; wb_writereg = 0; wb_result = 32'h99;
        step("r0_use");
        chk("r0_val", aluOutStored, 32'd2);

        // ALU ops on A=-1, B=1
        foreach (ops[i]) begin
            clear_in();
            rsDt = 32'hFFFF_FFFF; rtDt = 1; aluControl = ops[i];
            step("aluop");
            chk($sformatf("aluop%0d", i), aluOutStored, opsx[i]);
        end

        // Immediate operand and rt destination
        clear_in();
        aluSrc = 1; signEx = 32'hFFFF_FFFC; rsDt = 8; regdst = 0; rtval = 9; rtDt = 32'h55;
        step("imm");
        chk("imm_alu", aluOutStored, 32'd4);
        chk("imm_wr", DW'(writeRegStored), 32'd9);
        chk("imm_wd", writeDataStored, 32'h55);

        // Branch taken, then squashed follower
        clear_in();
        branch = 1; aluControl = 3'b110; rsDt = 5; rtDt = 5; pcvalue = 32'h100; signEx = 3;
        step("beq_t");
        chk("beq_t_bd", DW'(branchDet), 32'd1);
        chk("beq_t_bt", branchTarget, 32'h10C);
        clear_in();
        regwrite = 1; memwrite = 1; memRead = 1; rsDt = 6;
        step("squash");
        chk("squash_rw", DW'(regwriteStored), 32'd0);
        chk("squash_mw", DW'(memwriteStored), 32'd0);
        chk("squash_bd", DW'(branchDet), 32'd0);

        // Branch not taken, follower passes
        clear_in();
        branch = 1; aluControl = 3'b110; rsDt = 1; rtDt = 2;
        step("beq_nt");
        chk("beq_nt_bd", DW'(branchDet), 32'd0);
        clear_in();
        regwrite = 1; memwrite = 1;
        step("nt_follow");
        chk("nt_follow_rw", DW'(regwriteStored), 32'd1);
        chk("nt_follow_mw", DW'(memwriteStored), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            pcvalue     = $urandom;
            rtDt        = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
            rsDt        = ($urandom_range(0, 2) == 0) ? rtDt : $urandom;
            signEx      = ($urandom_range(0, 1) == 0) ? $urandom : DW'($signed(16'($urandom)));
            wb_result   = $urandom;
            rsval       = AW'($urandom_range(0, 3));
            rtval       = AW'($urandom_range(0, 3));
            rdval       = AW'($urandom_range(0, 3));
            wb_writereg = AW'($urandom_range(0, 3));
            memtoreg    = 1'($urandom);
            memwrite    = 1'($urandom);
            memRead     = 1'($urandom);
            branch      = ($urandom_range(0, 2) == 0);
            aluSrc      = ($urandom_range(0, 3) == 0);
            regdst      = 1'($urandom);
            regwrite    = 1'($urandom);
            wb_regwrite = 1'($urandom);
            aluControl  = 3'($urandom);
            step("rnd");
            if ($urandom_range(0, 59) == 0) mid_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
